stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter MIN_MAX, default 59, SHALL set the maximum minutes value (BCD-legal, 1..99) before minutes wrap to 00.
REQ-002 clk  input  1  SHALL be the single system clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 tick_1hz  input  1  SHALL be a one-cycle-wide count enable, asserted once per second.
REQ-005 tick_2hz  input  1  SHALL be a one-cycle-wide adjust/blink enable, asserted twice per second.
REQ-006 pause_pulse  input  1  SHALL be a debounced, one-cycle pause-toggle request.
REQ-007 clr_pulse  input  1  SHALL be a debounced, one-cycle synchronous clear request.
REQ-008 sel  input  1  SHALL select the adjust field: 0 = minutes, 1 = seconds.
REQ-009 adj  input  1  SHALL enable adjust mode when high; it is level-sensitive and pre-synchronised.
REQ-010 min_bcd  output  8  SHALL carry the minutes value as two BCD digits, tens in [7:4].
REQ-011 sec_bcd  output  8  SHALL carry the seconds value as two BCD digits, tens in [7:4].
REQ-012 blank_min  output  1  SHALL be high when the display driver must blank the minutes digits.
REQ-013 blank_sec  output  1  SHALL be high when the display driver must blank the seconds digits.
REQ-014 running  output  1  SHALL be high when the RUN state is active.

Function
REQ-015 The block SHALL implement four states: RUN, PAUSED, ADJ_RUN and ADJ_PAUSED; running SHALL be 1 only in RUN and ADJ_RUN.
REQ-016 In every state, pause_pulse SHALL toggle between the run and paused variants: RUN<->PAUSED and ADJ_RUN<->ADJ_PAUSED.
REQ-017 adj=1, sampled each cycle, SHALL move RUN->ADJ_RUN and PAUSED->ADJ_PAUSED on the next edge; adj=0 SHALL perform the reverse moves.
REQ-018 In RUN, each tick_1hz SHALL increment mm:ss by one second.
REQ-019 In RUN, seconds SHALL step 59->00 with a carry into minutes, and minutes SHALL step MIN_MAX->00, so MIN_MAX:59 wraps to 00:00.
REQ-020 In ADJ_RUN, each tick_2hz SHALL increment only the selected field, modulo (59+1) for seconds or (MIN_MAX+1) for minutes, with no carry between fields.
REQ-021 In ADJ_RUN, tick_1hz SHALL be ignored.
REQ-022 In PAUSED and ADJ_PAUSED, mm:ss SHALL hold.
REQ-023 Every BCD digit SHALL remain legal: ones 0-9, seconds tens 0-5; arithmetic SHALL be per-digit BCD and SHALL NOT use binary-to-BCD conversion.
REQ-024 clr_pulse SHALL set mm:ss to 00:00 on the next edge in any state without changing the state.
REQ-025 clr_pulse SHALL take priority over a coincident tick.
REQ-026 A pause_pulse coincident with a tick SHALL see the tick applied according to the state before the toggle, so a RUN tick still counts in that cycle.
REQ-027 A change on sel SHALL redirect adjust increments from the next tick_2hz onward.
REQ-028 An internal blink_phase SHALL toggle on every tick_2hz in all states, giving a 1 Hz blink.
REQ-029 blank_min SHALL equal (ADJ_* state & sel=0 & blink_phase), and blank_sec SHALL equal (ADJ_* state & sel=1 & blink_phase).
REQ-030 All outputs SHALL be registered, with a latency of exactly one clk cycle from the causing input to the output change.

Reset
REQ-031 While rst_n=0, the block SHALL immediately force state=RUN, min_bcd=8'h00, sec_bcd=8'h00, blink_phase=0, blank_min=0, blank_sec=0 and running=1.
REQ-032 Deasserting rst_n mid-count SHALL resume counting from 00:00 on the first tick_1hz after release; no tick received during reset SHALL be counted.

Verification
REQ-033 The bench SHALL cover: reset, then 61 tick_1hz pulses -> min_bcd=8'h01, sec_bcd=8'h01, running=1.
REQ-034 The bench SHALL cover: preload to MIN_MAX:59 (59:59), then one tick_1hz -> 00:00.
REQ-035 The bench SHALL cover: pause_pulse, then 5 tick_1hz -> counts unchanged and running=0; a second pause_pulse, then 1 tick -> +1 s.
REQ-036 The bench SHALL cover: adj=1, sel=1 from 00:58, then 3 tick_2hz -> 00:01 with minutes unchanged; blank_sec toggling, blank_min=0.
REQ-037 The bench SHALL cover: clr_pulse coincident with tick_1hz at 12:34 -> 00:00, state retained.
REQ-038 The bench SHALL cover: rst_n pulsed low for 3 cycles mid-count at 07:15 -> outputs reach reset values asynchronously, then counting resumes from 00:00.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its environment:
// tick/pulse/control inputs toward the controller, BCD display data back out.
interface stopwatch_ctrl_if;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       pause_pulse;
    logic       clr_pulse;
    logic       sel;
    logic       adj;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       blank_min;
    logic       blank_sec;
    logic       running;

    modport master (
        output tick_1hz, tick_2hz, pause_pulse, clr_pulse, sel, adj,
        input  min_bcd, sec_bcd, blank_min, blank_sec, running
    );

    modport slave (
        input  tick_1hz, tick_2hz, pause_pulse, clr_pulse, sel, adj,
        output min_bcd, sec_bcd, blank_min, blank_sec, running
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// mm:ss stopwatch with run/pause and per-field adjust modes, per-digit BCD
// counting and a 1 Hz blink of the field being adjusted.
module stopwatch_ctrl #(
    parameter int MIN_MAX = 59
) (
    input  logic            clk,
    input  logic            rst_n,
    stopwatch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        PAUSED     = 2'd1,
        ADJ_RUN    = 2'd2,
        ADJ_PAUSED = 2'd3
    } state_t;

    // The wrap limit is a decimal parameter; it is expressed once as a BCD
    // constant so the run-time comparison stays digit-wise.
    localparam logic [7:0] MIN_MAX_BCD = 8'(((MIN_MAX / 10) * 16) + (MIN_MAX % 10));
    localparam logic [7:0] SEC_MAX_BCD = 8'h59;

    state_t     state_reg, state_next;
    logic [7:0] min_reg, min_next;
    logic [7:0] sec_reg, sec_next;
    logic       blink_reg, blink_next;
    logic       running_reg, running_next;
    logic       blank_min_reg, blank_min_next;
    logic       blank_sec_reg, blank_sec_next;
    logic       adj_mode_next;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            min_reg       <= 8'h00;
            sec_reg       <= 8'h00;
            blink_reg     <= 1'b0;
            running_reg   <= 1'b1;
            blank_min_reg <= 1'b0;
            blank_sec_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            min_reg       <= min_next;
            sec_reg       <= sec_next;
            blink_reg     <= blink_next;
            running_reg   <= running_next;
            blank_min_reg <= blank_min_next;
            blank_sec_reg <= blank_sec_next;
        end
    end

    // The next state depends only on the toggled run/pause flavour and the
    // adj level, so simultaneous pause and adj requests combine cleanly.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN, ADJ_RUN: begin
                if (bus.pause_pulse) state_next = bus.adj ? ADJ_PAUSED : PAUSED;
                else                 state_next = bus.adj ? ADJ_RUN    : RUN;
            end
            PAUSED, ADJ_PAUSED: begin
                if (bus.pause_pulse) state_next = bus.adj ? ADJ_RUN    : RUN;
                else                 state_next = bus.adj ? ADJ_PAUSED : PAUSED;
            end
            default: state_next = RUN;
        endcase
    end

    // Ticks are judged against the current state, so a tick that coincides
    // with a pause toggle still acts as the pre-toggle state dictates.
    always_comb begin
        min_next = min_reg;
        sec_next = sec_reg;
        if (bus.clr_pulse) begin
            min_next = 8'h00;
            sec_next = 8'h00;
        end else if (state_reg == RUN && bus.tick_1hz) begin
            sec_next = bcd_inc(sec_reg, SEC_MAX_BCD);
            if (sec_reg == SEC_MAX_BCD) begin
                min_next = bcd_inc(min_reg, MIN_MAX_BCD);
            end
        end else if (state_reg == ADJ_RUN && bus.tick_2hz) begin
            if (bus.sel) sec_next = bcd_inc(sec_reg, SEC_MAX_BCD);
            else         min_next = bcd_inc(min_reg, MIN_MAX_BCD);
        end
    end

    always_comb begin
        blink_next     = blink_reg ^ bus.tick_2hz;
        adj_mode_next  = (state_next == ADJ_RUN) || (state_next == ADJ_PAUSED);
        running_next   = (state_next == RUN) || (state_next == ADJ_RUN);
        blank_min_next = adj_mode_next & ~bus.sel & blink_next;
        blank_sec_next = adj_mode_next &  bus.sel & blink_next;
    end

    assign bus.min_bcd   = min_reg;
    assign bus.sec_bcd   = sec_reg;
    assign bus.running   = running_reg;
    assign bus.blank_min = blank_min_reg;
    assign bus.blank_sec = blank_sec_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus a randomized run, all
// checked against an integer-seconds reference model.
module tb_stopwatch_ctrl;

    localparam int MIN_MAX = 59;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    stopwatch_ctrl_if bus();

    stopwatch_ctrl #(.MIN_MAX(MIN_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer minutes/seconds plus mode flags.
    int m_min, m_sec;
    bit m_paused, m_adj, m_blink, m_bmin, m_bsec;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic model_reset();
        m_min = 0; m_sec = 0;
        m_paused = 0; m_adj = 0; m_blink = 0; m_bmin = 0; m_bsec = 0;
    endtask

    task automatic model_step();
        if (bus.clr_pulse) begin
            m_min = 0; m_sec = 0;
        end else if (!m_paused && !m_adj && bus.tick_1hz) begin
            m_sec = m_sec + 1;
            if (m_sec == 60) begin
                m_sec = 0;
                m_min = (m_min == MIN_MAX) ? 0 : m_min + 1;
            end
        end else if (!m_paused && m_adj && bus.tick_2hz) begin
            if (bus.sel) m_sec = (m_sec + 1) % 60;
            else         m_min = (m_min + 1) % (MIN_MAX + 1);
        end
        if (bus.pause_pulse) m_paused = !m_paused;
        m_adj = bus.adj;
        if (bus.tick_2hz) m_blink = !m_blink;
        m_bmin = m_adj && !bus.sel && m_blink;
        m_bsec = m_adj &&  bus.sel && m_blink;
    endtask

    task automatic cycle(input bit t1, input bit t2, input bit p, input bit c);
        bus.tick_1hz    = t1;
        bus.tick_2hz    = t2;
        bus.pause_pulse = p;
        bus.clr_pulse   = c;
        @(posedge clk);
        model_step();
        #1;
        bus.tick_1hz    = 1'b0;
        bus.tick_2hz    = 1'b0;
        bus.pause_pulse = 1'b0;
        bus.clr_pulse   = 1'b0;
    endtask

    // Drives the adjust mode until the model shows the requested mm:ss.
    task automatic preload(input int mm, input int ss);
        int g;
        bus.adj = 1'b1;
        bus.sel = 1'b0;
        cycle(0, 0, 0, 0);
        g = 0;
        while (m_min != mm && g < 200) begin cycle(0, 1, 0, 0); g++; end
        bus.sel = 1'b1;
        while (m_sec != ss && g < 400) begin cycle(0, 1, 0, 0); g++; end
        bus.adj = 1'b0;
        cycle(0, 0, 0, 0);
        if (g >= 400) begin
            miscompares++;
            $display("FAIL preload_bound loop budget exhausted at %0d:%0d, wanted %0d:%0d", m_min, m_sec, mm, ss);
        end
    endtask

    task automatic test_reset();
        bus.tick_1hz = 0; bus.tick_2hz = 0; bus.pause_pulse = 0;
        bus.clr_pulse = 0; bus.sel = 0; bus.adj = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        vectors += 5;
        if (bus.min_bcd !== 8'h00) begin miscompares++; $display("FAIL reset_min got %h want 00", bus.min_bcd); end
        if (bus.sec_bcd !== 8'h00) begin miscompares++; $display("FAIL reset_sec got %h want 00", bus.sec_bcd); end
        if (bus.running !== 1'b1) begin miscompares++; $display("FAIL reset_running got %b want 1", bus.running); end
        if (bus.blank_min !== 1'b0) begin miscompares++; $display("FAIL reset_blank_min got %b want 0", bus.blank_min); end
        if (bus.blank_sec !== 1'b0) begin miscompares++; $display("FAIL reset_blank_sec got %b want 0", bus.blank_sec); end
        rst_n = 1'b1;
        $display("reset: min=%h sec=%h running=%b", bus.min_bcd, bus.sec_bcd, bus.running);
    endtask

    task automatic test_count61();
        for (int i = 0; i < 61; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int j = 0; j < gap; j++) cycle(0, 1'($urandom_range(0, 1)), 0, 0);
            cycle(1, 0, 0, 0);
        end
        vectors += 3;
        if (bus.min_bcd !== 8'h01) begin miscompares++; $display("FAIL count61_min got %h want 01", bus.min_bcd); end
        if (bus.sec_bcd !== 8'h01) begin miscompares++; $display("FAIL count61_sec got %h want 01", bus.sec_bcd); end
        if (bus.running !== 1'b1) begin miscompares++; $display("FAIL count61_running got %b want 1", bus.running); end
        $display("count61: min=%h sec=%h running=%b", bus.min_bcd, bus.sec_bcd, bus.running);
    endtask

    task automatic test_wrap();
        preload(MIN_MAX, 59);
        vectors++;
        if ({bus.min_bcd, bus.sec_bcd} !== 16'h5959) begin
            miscompares++; $display("FAIL wrap_preload got %h:%h want 59:59", bus.min_bcd, bus.sec_bcd);
        end
        cycle(1, 0, 0, 0);
        vectors++;
        if ({bus.min_bcd, bus.sec_bcd} !== 16'h0000) begin
            miscompares++; $display("FAIL wrap_tick got %h:%h want 00:00", bus.min_bcd, bus.sec_bcd);
        end
        $display("wrap: %h:%h after one tick from 59:59", bus.min_bcd, bus.sec_bcd);
    endtask

    task automatic test_pause();
        int s0;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        s0 = m_sec;
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
        vectors += 2;
        if ({bus.min_bcd, bus.sec_bcd} !== {to_bcd(0), to_bcd(s0)}) begin
            miscompares++; $display("FAIL pause_hold got %h:%h want 00:%h", bus.min_bcd, bus.sec_bcd, to_bcd(s0));
        end
        if (bus.running !== 1'b0) begin miscompares++; $display("FAIL pause_running got %b want 0", bus.running); end
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        vectors += 2;
        if (bus.sec_bcd !== to_bcd(s0 + 1)) begin
            miscompares++; $display("FAIL resume_tick got %h want %h", bus.sec_bcd, to_bcd(s0 + 1));
        end
        if (bus.running !== 1'b1) begin miscompares++; $display("FAIL resume_running got %b want 1", bus.running); end
        // Pause coinciding with a tick: the tick counts while leaving RUN,
        // and is ignored while leaving PAUSED.
        cycle(1, 0, 1, 0);
        vectors++;
        if ({bus.sec_bcd, bus.running} !== {to_bcd(s0 + 2), 1'b0}) begin
            miscompares++; $display("FAIL pause_tick_run got sec=%h run=%b want sec=%h run=0", bus.sec_bcd, bus.running, to_bcd(s0 + 2));
        end
        cycle(1, 0, 1, 0);
        vectors++;
        if ({bus.sec_bcd, bus.running} !== {to_bcd(s0 + 2), 1'b1}) begin
            miscompares++; $display("FAIL pause_tick_paused got sec=%h run=%b want sec=%h run=1", bus.sec_bcd, bus.running, to_bcd(s0 + 2));
        end
        $display("pause: sec=%h running=%b", bus.sec_bcd, bus.running);
    endtask

    task automatic test_adjust();
        cycle(0, 0, 0, 1);
        preload(0, 58);
        bus.adj = 1'b1;
        bus.sel = 1'b1;
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0);
            vectors += 2;
            if (bus.blank_sec !== m_bsec) begin miscompares++; $display("FAIL adj_blank_sec[%0d] got %b want %b", i, bus.blank_sec, m_bsec); end
            if (bus.blank_min !== 1'b0) begin miscompares++; $display("FAIL adj_blank_min[%0d] got %b want 0", i, bus.blank_min); end
            cycle(1, 0, 0, 0);
        end
        vectors++;
        if ({bus.min_bcd, bus.sec_bcd} !== 16'h0001) begin
            miscompares++; $display("FAIL adj_sec got %h:%h want 00:01", bus.min_bcd, bus.sec_bcd);
        end
        bus.sel = 1'b0;
        cycle(0, 1, 0, 0);
        vectors += 2;
        if ({bus.min_bcd, bus.sec_bcd} !== 16'h0101) begin
            miscompares++; $display("FAIL adj_redirect got %h:%h want 01:01", bus.min_bcd, bus.sec_bcd);
        end
        if ({bus.blank_min, bus.blank_sec} !== {m_bmin, 1'b0}) begin
            miscompares++; $display("FAIL adj_redirect_blank got %b%b want %b0", bus.blank_min, bus.blank_sec, m_bmin);
        end
        bus.adj = 1'b0;
        cycle(0, 0, 0, 0);
        $display("adjust: %h:%h blank_min=%b blank_sec=%b", bus.min_bcd, bus.sec_bcd, bus.blank_min, bus.blank_sec);
    endtask

    task automatic test_clr_tick();
        cycle(0, 0, 0, 1);
        preload(12, 34);
        vectors++;
        if ({bus.min_bcd, bus.sec_bcd} !== 16'h1234) begin
            miscompares++; $display("FAIL clr_preload got %h:%h want 12:34", bus.min_bcd, bus.sec_bcd);
        end
        cycle(1, 0, 0, 1);
        vectors++;
        if ({bus.min_bcd, bus.sec_bcd, bus.running} !== {16'h0000, 1'b1}) begin
            miscompares++; $display("FAIL clr_tick_run got %h:%h run=%b want 00:00 run=1", bus.min_bcd, bus.sec_bcd, bus.running);
        end
        repeat (3) cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 1);
        vectors++;
        if ({bus.min_bcd, bus.sec_bcd, bus.running} !== {16'h0000, 1'b0}) begin
            miscompares++; $display("FAIL clr_tick_paused got %h:%h run=%b want 00:00 run=0", bus.min_bcd, bus.sec_bcd, bus.running);
        end
        cycle(0, 0, 1, 0);
        $display("clr: %h:%h running=%b", bus.min_bcd, bus.sec_bcd, bus.running);
    endtask

    task automatic test_reset_mid();
        cycle(0, 0, 0, 1);
        preload(7, 15);
        vectors++;
        if ({bus.min_bcd, bus.sec_bcd} !== 16'h0715) begin
            miscompares++; $display("FAIL rstmid_preload got %h:%h want 07:15", bus.min_bcd, bus.sec_bcd);
        end
        bus.adj = 1'b1;
        bus.sel = 1'b0;
        cycle(0, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.min_bcd, bus.sec_bcd, bus.running, bus.blank_min, bus.blank_sec} !== {16'h0000, 3'b100}) begin
            miscompares++; $display("FAIL rstmid_async got %h:%h run=%b bm=%b bs=%b want 00:00 run=1 bm=0 bs=0",
                                    bus.min_bcd, bus.sec_bcd, bus.running, bus.blank_min, bus.blank_sec);
        end
        bus.adj = 1'b0;
        bus.tick_1hz = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.tick_1hz = 1'b0;
        vectors++;
        if ({bus.min_bcd, bus.sec_bcd} !== 16'h0000) begin
            miscompares++; $display("FAIL rstmid_hold got %h:%h want 00:00", bus.min_bcd, bus.sec_bcd);
        end
        #2;
        rst_n = 1'b1;
        model_reset();
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        vectors++;
        if ({bus.min_bcd, bus.sec_bcd, bus.running} !== {16'h0001, 1'b1}) begin
            miscompares++; $display("FAIL rstmid_resume got %h:%h run=%b want 00:01 run=1", bus.min_bcd, bus.sec_bcd, bus.running);
        end
        $display("reset_mid: resumed at %h:%h", bus.min_bcd, bus.sec_bcd);
    endtask

    task automatic test_random();
        logic [18:0] got, exp;
        int bad = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 40) == 0) bus.adj = !bus.adj;
            if ($urandom_range(0, 6) == 0) bus.sel = !bus.sel;
            cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 30) == 0), 1'($urandom_range(0, 200) == 0));
            got = {bus.min_bcd, bus.sec_bcd, bus.running, bus.blank_min, bus.blank_sec};
            exp = {to_bcd(m_min), to_bcd(m_sec), !m_paused, m_bmin, m_bsec};
            vectors++;
            if (got !== exp) begin
                miscompares++; bad++;
                if (bad <= 10) $display("FAIL random[%0d] got %h want %h", i, got, exp);
            end
        end
        bus.adj = 1'b0;
        cycle(0, 0, 0, 0);
        $display("random: 1500 cycles, final %h:%h", bus.min_bcd, bus.sec_bcd);
    endtask

    initial begin
        test_reset();
        test_count61();
        test_wrap();
        test_pause();
        test_adjust();
        test_clr_tick();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
